// File: rtl/pushpop_sequencer.sv
// pushpop_sequencer: walks a PUSH/POP register list one memory access per transfer, writing SP once at the end.
// Define PUSHPOP_EXTRA_EN to honour extra_i (LR on PUSH, PC on POP) as a final transfer slot.
module pushpop_sequencer #(
  parameter int NREGS      = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [NREGS-1:0] rlist_i,
  input  logic             extra_i,
  input  logic [15:0]      sp_i,
  input  logic             mem_ready_i,
  output logic             busy_o,
  output logic [15:0]      mem_addr_o,
  output logic             mem_load_o,
  output logic             mem_write_o,
  output logic [3:0]       reg_sel_o,
  output logic             rf_write_en_o,
  output logic             mem2reg_o,
  output logic             sp_write_en_o,
  output logic [15:0]      sp_o,
  output logic             done_o
);
`ifdef PUSHPOP_EXTRA_EN
  localparam int M = NREGS + 1;
`else
  localparam int M = NREGS;
`endif
  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;
  state_t      state_q, state_d;
  logic [M-1:0] mask_q, mask_d, start_mask, mask_next;
  logic        load_q, load_d, nz_q, nz_d, ext;
  logic [15:0] addr_q, addr_d, sp_fin_q, sp_fin_d, step;
  logic [4:0]  n;
  logic [3:0]  idx;
`ifdef PUSHPOP_EXTRA_EN
  assign ext        = extra_i;
  assign start_mask = {extra_i, rlist_i};
`else
  logic unused_extra;
  assign unused_extra = extra_i;
  assign ext          = 1'b0;
  assign start_mask   = rlist_i;
`endif
  // The extra slot sits above the low registers, so lowest-set-bit order transfers it last.
  always_comb begin
    n = 5'(ext);
    for (int i = 0; i < NREGS; i++) n = n + 5'(rlist_i[i]);
    step = 16'(n) * 16'(WORD_BYTES);
    idx = '0;
    for (int i = M - 1; i >= 0; i--) if (mask_q[i]) idx = 4'(i);
    mask_next = mask_q & (mask_q - M'(1));
  end
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    load_d   = load_q;
    nz_d     = nz_q;
    addr_d   = addr_q;
    sp_fin_d = sp_fin_q;
    if (state_q == IDLE && start_i) begin
      state_d  = (n == 5'd0) ? FINISH : XFER;
      mask_d   = start_mask;
      load_d   = load_i;
      nz_d     = n != 5'd0;
      addr_d   = load_i ? sp_i : sp_i - step;
      sp_fin_d = load_i ? sp_i + step : sp_i - step;
    end else if (state_q == XFER && mem_ready_i) begin
      mask_d  = mask_next;
      addr_d  = addr_q + 16'(WORD_BYTES);
      state_d = (mask_next == '0) ? FINISH : XFER;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      load_q   <= 1'b0;
      nz_q     <= 1'b0;
      addr_q   <= '0;
      sp_fin_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      load_q   <= load_d;
      nz_q     <= nz_d;
      addr_q   <= addr_d;
      sp_fin_q <= sp_fin_d;
    end
  end
  always_comb begin
    busy_o        = state_q != IDLE;
    mem_addr_o    = (state_q == XFER) ? addr_q : 16'h0000;
    mem_load_o    = state_q == XFER && load_q;
    mem_write_o   = state_q == XFER && !load_q;
    reg_sel_o     = (state_q != XFER) ? 4'd0 : (idx == 4'(NREGS)) ? (load_q ? 4'd15 : 4'd14) : idx;
    rf_write_en_o = mem_load_o && mem_ready_i;
    mem2reg_o     = rf_write_en_o;
    sp_write_en_o = state_q == FINISH && nz_q;
    sp_o          = sp_write_en_o ? sp_fin_q : 16'h0000;
    done_o        = state_q == FINISH;
  end
endmodule

// File: tb/tb_pushpop_sequencer.sv
// tb_pushpop_sequencer: directed and randomized PUSH/POP sequences checked against a transfer-list model.
module tb_pushpop_sequencer;
  localparam int NR = 8;
  localparam int WB = 4;
  typedef struct {
    logic          ld;
    logic [NR-1:0] rl;
    logic          ex;
    logic [15:0]   sp;
    int            waits;
  } op_t;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, load_i = 1'b0, extra_i = 1'b0, mem_ready_i = 1'b0;
  logic [NR-1:0] rlist_i = '0;
  logic [15:0]   sp_i = '0;
  logic busy_o, mem_load_o, mem_write_o, rf_write_en_o, mem2reg_o, sp_write_en_o, done_o;
  logic [15:0] mem_addr_o, sp_o;
  logic [3:0]  reg_sel_o;
  logic [42:0] obs, exp_v;
  int checks = 0, errors = 0;
  always #5 clk_i = ~clk_i;
  pushpop_sequencer #(.NREGS(NR), .WORD_BYTES(WB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_i(load_i), .rlist_i(rlist_i),
    .extra_i(extra_i), .sp_i(sp_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_load_o(mem_load_o), .mem_write_o(mem_write_o),
    .reg_sel_o(reg_sel_o), .rf_write_en_o(rf_write_en_o), .mem2reg_o(mem2reg_o),
    .sp_write_en_o(sp_write_en_o), .sp_o(sp_o), .done_o(done_o)
  );
  assign obs = {busy_o, mem_load_o, mem_write_o, reg_sel_o, mem_addr_o, rf_write_en_o,
                mem2reg_o, sp_write_en_o, sp_o, done_o};
  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 43'd0) begin errors++; $display("FAIL reset: got %h want %h", obs, 43'd0); end
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (obs !== 43'd0) begin errors++; $display("FAIL reset_release: got %h want %h", obs, 43'd0); end
  endtask
  task automatic test_transfers();
    op_t q[$];
    op_t o;
    int exp_reg[$];
    int n, w;
    logic ex;
    logic [15:0] base, fin;
    q.push_back('{1'b0, 8'h05, 1'b0, 16'h0100, 0});
    q.push_back('{1'b1, 8'h02, 1'b1, 16'h00F8, 0});
    q.push_back('{1'b0, 8'h08, 1'b0, 16'h0100, 2});
    q.push_back('{1'b0, 8'h00, 1'b0, 16'h0040, 0});
    q.push_back('{1'b0, 8'h01, 1'b0, 16'h0002, 0});
    q.push_back('{1'b1, 8'h0F, 1'b1, 16'hFFF8, 1});
    for (int r = 0; r < 40; r++)
      q.push_back('{1'($urandom), ($urandom_range(4, 0) == 0) ? '0 : NR'($urandom),
                    1'($urandom), 16'($urandom), -1});
    for (int i = 0; i < q.size(); i++) begin
      o = q[i];
      exp_reg.delete();
      for (int k = 0; k < NR; k++) if (o.rl[k]) exp_reg.push_back(k);
`ifdef PUSHPOP_EXTRA_EN
      ex = o.ex;
`else
      ex = 1'b0;
`endif
      if (ex) exp_reg.push_back(o.ld ? 15 : 14);
      n = exp_reg.size();
      base = o.ld ? o.sp : o.sp - 16'(WB * n);
      fin = o.ld ? o.sp + 16'(WB * n) : base;
      @(negedge clk_i);
      start_i = 1'b1; load_i = o.ld; rlist_i = o.rl; extra_i = o.ex; sp_i = o.sp; mem_ready_i = 1'b0;
      @(posedge clk_i); #1;
      for (int t = 0; t < n; t++) begin
        w = (o.waits < 0) ? int'($urandom_range(2, 0)) : o.waits;
        for (int c = 0; c <= w; c++) begin
          mem_ready_i = (c == w);
          start_i = 1'b1; load_i = 1'($urandom); rlist_i = NR'($urandom);
          extra_i = 1'($urandom); sp_i = 16'($urandom);
          @(negedge clk_i);
          exp_v = {1'b1, o.ld, !o.ld, 4'(exp_reg[t]), base + 16'(WB * t), o.ld && c == w,
                   o.ld && c == w, 1'b0, 16'h0000, 1'b0};
          checks++;
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL xfer op%0d t%0d c%0d: got %h want %h", i, t, c, obs, exp_v);
          end
          @(posedge clk_i); #1;
        end
      end
      mem_ready_i = 1'b0;
      @(negedge clk_i);
      exp_v = {1'b1, 2'b00, 4'd0, 16'h0000, 2'b00, n > 0, (n > 0) ? fin : 16'h0000, 1'b1};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL finish op%0d: got %h want %h", i, obs, exp_v); end
      @(posedge clk_i); #1 start_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (obs !== 43'd0) begin errors++; $display("FAIL idle op%0d: got %h want %h", i, obs, 43'd0); end
    end
  endtask
  task automatic test_reset_midop();
    @(negedge clk_i);
    start_i = 1'b1; load_i = 1'b0; rlist_i = 8'hFF; extra_i = 1'b0; sp_i = 16'h0100; mem_ready_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    exp_v = {1'b1, 1'b0, 1'b1, 4'd0, 16'h00E0, 3'b000, 16'h0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL midop_first: got %h want %h", obs, exp_v); end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 43'd0) begin errors++; $display("FAIL midop_reset: got %h want %h", obs, 43'd0); end
    @(posedge clk_i); #1 rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 43'd0) begin errors++; $display("FAIL after_reset c%0d: got %h want %h", c, obs, 43'd0); end
    end
    start_i = 1'b1; load_i = 1'b1; rlist_i = 8'h01; sp_i = 16'h0010; mem_ready_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    @(negedge clk_i);
    exp_v = {1'b1, 1'b1, 1'b0, 4'd0, 16'h0010, 3'b110, 16'h0000, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL restart_xfer: got %h want %h", obs, exp_v); end
    @(posedge clk_i); #1 mem_ready_i = 1'b0;
    @(negedge clk_i);
    exp_v = {1'b1, 2'b00, 4'd0, 16'h0000, 3'b001, 16'h0014, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL restart_finish: got %h want %h", obs, exp_v); end
    @(posedge clk_i); #1;
  endtask
  initial begin
    test_reset();
    test_transfers();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
